wb_commit: RTL and testbench
============================

Name: wb_commit

Overview:
- Writeback/commit stage directly downstream of the memory stage.
- Registers the memory stage's regfile write request and drives the regfile write port one cycle later.
- Owns the machine-mode CSRs: mstatus, mtvec, mscratch, mepc, mcause, mcycle, minstret.
- Commits traps and MRET: issues a PC redirect plus a multi-cycle pipeline flush, and provides a combinational CSR read port for the execute stage.

Parameters:
- XLEN, 64, datapath width.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (legal range 1..15).
- MTVEC_RESET, 64'h8000_0000, mtvec reset value (equals PMEM_START).

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- valid_i  in  1  memory stage holds a live instruction this cycle.
- wen_i  in  1  regfile write request.
- rd_i  in  5  destination register.
- wdata_i  in  XLEN  regfile write data (load data, ALU result or SC status).
- csr_wen_i  in  1  CSR write request.
- csr_addr_i  in  12  CSR write address.
- csr_wdata_i  in  XLEN  CSR write data.
- exception_i  in  1  instruction raised an exception.
- mcause_i  in  XLEN  cause code.
- pc_i  in  XLEN  instruction PC.
- mret_i  in  1  instruction is MRET.
- csr_raddr_i  in  12  execute-stage CSR read address.
- csr_rdata_o  out  XLEN  combinational CSR read data.
- rf_wen_o  out  1  registered regfile write enable.
- rf_rd_o  out  5  registered destination register.
- rf_wdata_o  out  XLEN  registered write data.
- redirect_valid_o  out  1  one-cycle pulse: fetch must jump.
- redirect_pc_o  out  XLEN  redirect target.
- flush_o  out  1  squash all younger stages.
- retire_o  out  1  registered pulse per retired instruction.

Behaviour:
- Reset (reset==0, async):
  - rf_wen_o=0, rf_rd_o=0, rf_wdata_o=0, redirect_valid_o=0, redirect_pc_o=0, flush_o=0, retire_o=0.
  - FSM=RUN, flush counter=0.
  - mstatus=0, mtvec=MTVEC_RESET, mscratch=mepc=mcause=mcycle=minstret=0.
- Live instruction: `live = valid_i & (state==RUN)`. Inputs arriving while state is FLUSH are discarded with no side effects.
- FSM RUN:
  - Exception: when live & exception_i:
    - mepc<=pc_i; mcause<=mcause_i.
    - mstatus.MPIE(bit7)<=MIE(bit3); MIE<=0.
    - redirect_pc_o<={mtvec[63:2],2'b00}.
    - Regfile write, CSR write and retire are suppressed.
    - Go to FLUSH.
  - MRET: when live & mret_i & !exception_i:
    - MIE<=MPIE; MPIE<=1.
    - redirect_pc_o<=mepc (the value before any same-cycle write).
    - MRET retires.
    - Go to FLUSH.
  - Exception beats MRET when both are set.
- FSM FLUSH:
  - redirect_valid_o is high only during the first FLUSH cycle.
  - flush_o stays high for exactly FLUSH_CYCLES cycles, then the FSM returns to RUN.
  - A reset mid-flush returns the FSM to RUN with flush_o=0.
- Regfile write:
  - Registered with 1-cycle latency.
  - `rf_wen_o <= live & wen_i & !exception_i & (rd_i!=0)`.
  - rf_rd_o and rf_wdata_o update only when the next rf_wen_o is 1; otherwise they hold.
- CSR write:
  - Takes effect when live & csr_wen_i & !exception_i.
  - Addresses: 0x300 mstatus (only bits 3 and 7 writable, others read 0), 0x305 mtvec, 0x340 mscratch, 0x341 mepc (bits[1:0] forced 0), 0x342 mcause, 0xB00 mcycle, 0xB02 minstret.
  - Writes to any other address are ignored.
- CSR read:
  - csr_rdata_o is the pre-edge register value, so a same-cycle write is not bypassed.
  - Unmapped addresses read 0.
- Counters:
  - mcycle increments every cycle; minstret increments on each retire.
  - A CSR write to a counter overrides that cycle's increment.
  - Both counters wrap modulo 2^64.
- retire_o <= live & !exception_i.

Optional Feature:
- Macro WB_COUNTERS_EN.
- Defined: mcycle and minstret are implemented as described above.
- Undefined: no counter flops exist; reads of 0xB00 and 0xB02 return 0; writes to them are ignored. retire_o is still produced.

Decomposition:
- Shared package / define.v holds:
  - CSR address constants (CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MINSTRET).
  - mstatus bit indices MSTATUS_MIE=3 and MSTATUS_MPIE=7.
  - FSM state encoding (WB_RUN, WB_FLUSH).
- Sub-module wb_csr_file holds the CSR storage, write decode, read mux and counters.
- wb_commit keeps the FSM, the regfile register stage and the redirect logic.

Test Plan:
- Reset release, then valid_i=1, wen_i=1, rd_i=5, wdata_i=64'h1234 -> next cycle rf_wen_o=1, rf_rd_o=5, rf_wdata_o=64'h1234, retire_o=1.
- wen_i=1, rd_i=0, wdata_i=64'hFF -> rf_wen_o=0, and retire_o=1 still.
- mstatus=64'h8, mtvec=64'h8000_0103, then exception_i=1, pc_i=64'h8000_0040, mcause_i=2:
  - mepc=64'h8000_0040, mcause=2, mstatus=64'h80.
  - redirect_valid_o pulses once with redirect_pc_o=64'h8000_0100.
  - flush_o is high 2 cycles; an instruction presented during the flush causes no regfile write.
- After the trap above, mret_i=1 -> redirect_pc_o=64'h8000_0040, mstatus=64'h88.
- Same cycle: csr_wen_i=1, csr_addr_i=12'h340, csr_wdata_i=64'hAA, csr_raddr_i=12'h340 -> csr_rdata_o returns old 0; the following cycle it returns 64'hAA.
- Write minstret=64'hFFFF_FFFF_FFFF_FFFF, then retire one instruction -> minstret reads 0. With WB_COUNTERS_EN undefined, the read returns 0 regardless.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared constants for the writeback/commit stage: CSR addresses, mstatus bit
// positions and the commit FSM state encoding.
package wb_commit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [0:0] WB_RUN   = 1'b0;
    localparam logic [0:0] WB_FLUSH = 1'b1;

endpackage

// File: rtl/wb_csr_file.sv
// Machine-mode CSR storage, write decode, read mux and counters.
// Counters exist only when WB_COUNTERS_EN is defined.
module wb_csr_file
    import wb_commit_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [11:0]     csr_raddr_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] mepc_o
);

    logic            mie_r;
    logic            mpie_r;
    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mscratch_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;

    // mstatus: trap entry and MRET take precedence over a software write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mie_r  <= 1'b0;
            mpie_r <= 1'b0;
        end else if (trap_i) begin
            mpie_r <= mie_r;
            mie_r  <= 1'b0;
        end else if (mret_i) begin
            mie_r  <= mpie_r;
            mpie_r <= 1'b1;
        end else if (csr_we_i && (csr_addr_i == CSR_MSTATUS)) begin
            mie_r  <= csr_wdata_i[MSTATUS_MIE];
            mpie_r <= csr_wdata_i[MSTATUS_MPIE];
        end
    end

    // Plain CSRs; csr_we_i is never set together with trap_i
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtvec_r    <= MTVEC_RESET;
            mscratch_r <= {XLEN{1'b0}};
            mepc_r     <= {XLEN{1'b0}};
            mcause_r   <= {XLEN{1'b0}};
        end else if (trap_i) begin
            mepc_r   <= trap_pc_i;
            mcause_r <= trap_cause_i;
        end else if (csr_we_i) begin
            case (csr_addr_i)
                CSR_MTVEC:    mtvec_r    <= csr_wdata_i;
                CSR_MSCRATCH: mscratch_r <= csr_wdata_i;
                CSR_MEPC:     mepc_r     <= {csr_wdata_i[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_r   <= csr_wdata_i;
                default:      mtvec_r    <= mtvec_r;
            endcase
        end
    end

`ifdef WB_COUNTERS_EN
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] mcycle_r;
    logic [XLEN-1:0] minstret_r;

    // Free-running counters; a software write wins over that cycle's increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcycle_r   <= {XLEN{1'b0}};
            minstret_r <= {XLEN{1'b0}};
        end else begin
            if (csr_we_i && (csr_addr_i == CSR_MCYCLE)) begin
                mcycle_r <= csr_wdata_i;
            end else begin
                mcycle_r <= mcycle_r + ONE;
            end
            if (csr_we_i && (csr_addr_i == CSR_MINSTRET)) begin
                minstret_r <= csr_wdata_i;
            end else if (retire_i) begin
                minstret_r <= minstret_r + ONE;
            end
        end
    end
`else
    logic unused_retire_s;
    assign unused_retire_s = retire_i;
`endif

    // Read mux returns pre-edge values; unmapped addresses read zero
    always_comb begin
        csr_rdata_o = {XLEN{1'b0}};
        case (csr_raddr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[MSTATUS_MIE]  = mie_r;
                csr_rdata_o[MSTATUS_MPIE] = mpie_r;
            end
            CSR_MTVEC:    csr_rdata_o = mtvec_r;
            CSR_MSCRATCH: csr_rdata_o = mscratch_r;
            CSR_MEPC:     csr_rdata_o = mepc_r;
            CSR_MCAUSE:   csr_rdata_o = mcause_r;
`ifdef WB_COUNTERS_EN
            CSR_MCYCLE:   csr_rdata_o = mcycle_r;
            CSR_MINSTRET: csr_rdata_o = minstret_r;
`endif
            default:      csr_rdata_o = {XLEN{1'b0}};
        endcase
    end

    assign trap_vec_o = {mtvec_r[XLEN-1:2], 2'b00};
    assign mepc_o     = mepc_r;

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: regfile write register, trap/MRET redirect FSM and
// machine CSRs (counters optional via WB_COUNTERS_EN).
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [XLEN-1:0] MTVEC_RESET  = 64'h0000_0000_8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_i,
    input  logic            wen_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            csr_wen_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            exception_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            mret_i,
    input  logic [11:0]     csr_raddr_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            rf_wen_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            retire_o
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    logic [0:0]      state_r;
    logic [3:0]      flush_cnt_r;
    logic            live_s;
    logic            trap_s;
    logic            mret_s;
    logic            csr_we_s;
    logic            retire_s;
    logic            rf_we_s;
    logic [XLEN-1:0] trap_vec_s;
    logic [XLEN-1:0] mepc_s;

    // Anything arriving while flushing is dropped without side effects
    assign live_s   = valid_i & (state_r == WB_RUN);
    assign trap_s   = live_s & exception_i;
    assign mret_s   = live_s & mret_i & ~exception_i;
    assign csr_we_s = live_s & csr_wen_i & ~exception_i;
    assign retire_s = live_s & ~exception_i;
    assign rf_we_s  = live_s & wen_i & ~exception_i & (rd_i != 5'd0);

    wb_csr_file #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clock        (clock),
        .reset        (reset),
        .csr_we_i     (csr_we_s),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .trap_i       (trap_s),
        .mret_i       (mret_s),
        .retire_i     (retire_s),
        .trap_pc_i    (pc_i),
        .trap_cause_i (mcause_i),
        .csr_raddr_i  (csr_raddr_i),
        .csr_rdata_o  (csr_rdata_o),
        .trap_vec_o   (trap_vec_s),
        .mepc_o       (mepc_s)
    );

    // Regfile write port and retire pulse, one cycle behind the memory stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_wen_o   <= 1'b0;
            rf_rd_o    <= 5'd0;
            rf_wdata_o <= {XLEN{1'b0}};
            retire_o   <= 1'b0;
        end else begin
            rf_wen_o <= rf_we_s;
            retire_o <= retire_s;
            if (rf_we_s) begin
                rf_rd_o    <= rd_i;
                rf_wdata_o <= wdata_i;
            end
        end
    end

    // Commit FSM: redirect pulses on the first flush cycle, flush lasts FLUSH_CYCLES
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r          <= WB_RUN;
            flush_cnt_r      <= 4'd0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= {XLEN{1'b0}};
            flush_o          <= 1'b0;
        end else begin
            case (state_r)
                WB_RUN: begin
                    redirect_valid_o <= 1'b0;
                    flush_o          <= 1'b0;
                    flush_cnt_r      <= 4'd0;
                    if (trap_s || mret_s) begin
                        state_r          <= WB_FLUSH;
                        redirect_valid_o <= 1'b1;
                        flush_o          <= 1'b1;
                        redirect_pc_o    <= trap_s ? trap_vec_s : mepc_s;
                    end
                end
                WB_FLUSH: begin
                    redirect_valid_o <= 1'b0;
                    if (flush_cnt_r == FLUSH_LAST) begin
                        state_r     <= WB_RUN;
                        flush_o     <= 1'b0;
                        flush_cnt_r <= 4'd0;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r          <= WB_RUN;
                    flush_cnt_r      <= 4'd0;
                    redirect_valid_o <= 1'b0;
                    flush_o          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit (default FLUSH_CYCLES=2).
module tb_wb_commit;

    logic        clock;
    logic        reset;
    logic        valid_i;
    logic        wen_i;
    logic [4:0]  rd_i;
    logic [63:0] wdata_i;
    logic        csr_wen_i;
    logic [11:0] csr_addr_i;
    logic [63:0] csr_wdata_i;
    logic        exception_i;
    logic [63:0] mcause_i;
    logic [63:0] pc_i;
    logic        mret_i;
    logic [11:0] csr_raddr_i;
    logic [63:0] csr_rdata_o;
    logic        rf_wen_o;
    logic [4:0]  rf_rd_o;
    logic [63:0] rf_wdata_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
    logic        flush_o;
    logic        retire_o;

    int tests_run = 0;
    int tests_failed = 0;

    wb_commit dut (
        .clock            (clock),
        .reset            (reset),
        .valid_i          (valid_i),
        .wen_i            (wen_i),
        .rd_i             (rd_i),
        .wdata_i          (wdata_i),
        .csr_wen_i        (csr_wen_i),
        .csr_addr_i       (csr_addr_i),
        .csr_wdata_i      (csr_wdata_i),
        .exception_i      (exception_i),
        .mcause_i         (mcause_i),
        .pc_i             (pc_i),
        .mret_i           (mret_i),
        .csr_raddr_i      (csr_raddr_i),
        .csr_rdata_o      (csr_rdata_o),
        .rf_wen_o         (rf_wen_o),
        .rf_rd_o          (rf_rd_o),
        .rf_wdata_o       (rf_wdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .retire_o         (retire_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rd_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr_raddr_i = addr;
        #1;
        chk(tag, csr_rdata_o, exp);
    endtask

    task automatic idle();
        valid_i = 1'b0; wen_i = 1'b0; rd_i = 5'd0; wdata_i = 64'd0;
        csr_wen_i = 1'b0; csr_addr_i = 12'h000; csr_wdata_i = 64'd0;
        exception_i = 1'b0; mcause_i = 64'd0; pc_i = 64'd0; mret_i = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
        idle();
        valid_i = 1'b1; csr_wen_i = 1'b1; csr_addr_i = addr; csr_wdata_i = data;
        tick();
        idle();
    endtask

    initial begin
        idle();
        csr_raddr_i = 12'h000;
        reset = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_rf_wen", 64'(rf_wen_o), 64'd0);
        chk("rst_rf_rd", 64'(rf_rd_o), 64'd0);
        chk("rst_rf_wdata", rf_wdata_o, 64'd0);
        chk("rst_redirect_valid", 64'(redirect_valid_o), 64'd0);
        chk("rst_redirect_pc", redirect_pc_o, 64'd0);
        chk("rst_flush", 64'(flush_o), 64'd0);
        chk("rst_retire", 64'(retire_o), 64'd0);
        rd_csr("rst_mtvec", 12'h305, 64'h8000_0000);
        rd_csr("rst_mstatus", 12'h300, 64'd0);
        rd_csr("rst_mepc", 12'h341, 64'd0);

        @(negedge clock);
        reset = 1'b1;

        // Ordinary regfile write
        valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd5; wdata_i = 64'h1234;
        tick();
        chk("wr_rf_wen", 64'(rf_wen_o), 64'd1);
        chk("wr_rf_rd", 64'(rf_rd_o), 64'd5);
        chk("wr_rf_wdata", rf_wdata_o, 64'h1234);
        chk("wr_retire", 64'(retire_o), 64'd1);

        // x0 write suppressed but still retires; rd/wdata hold
        rd_i = 5'd0; wdata_i = 64'hFF;
        tick();
        chk("x0_rf_wen", 64'(rf_wen_o), 64'd0);
        chk("x0_rf_rd_hold", 64'(rf_rd_o), 64'd5);
        chk("x0_rf_wdata_hold", rf_wdata_o, 64'h1234);
        chk("x0_retire", 64'(retire_o), 64'd1);
        idle();

        // mstatus write mask, then set MIE and mtvec
        csr_write(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_csr("mstatus_mask", 12'h300, 64'h88);
        csr_write(12'h300, 64'h8);
        rd_csr("mstatus_mie", 12'h300, 64'h8);
        csr_write(12'h305, 64'h8000_0103);
        rd_csr("mtvec_wr", 12'h305, 64'h8000_0103);

        // Exception with regfile and CSR write requests that must be suppressed
        valid_i = 1'b1; exception_i = 1'b1; pc_i = 64'h8000_0040; mcause_i = 64'd2;
        wen_i = 1'b1; rd_i = 5'd7; wdata_i = 64'hDEAD;
        csr_wen_i = 1'b1; csr_addr_i = 12'h340; csr_wdata_i = 64'h55;
        tick();
        chk("trap_redirect_valid", 64'(redirect_valid_o), 64'd1);
        chk("trap_redirect_pc", redirect_pc_o, 64'h8000_0100);
        chk("trap_flush1", 64'(flush_o), 64'd1);
        chk("trap_rf_wen", 64'(rf_wen_o), 64'd0);
        chk("trap_retire", 64'(retire_o), 64'd0);
        rd_csr("trap_mepc", 12'h341, 64'h8000_0040);
        rd_csr("trap_mcause", 12'h342, 64'd2);
        rd_csr("trap_mstatus", 12'h300, 64'h80);
        rd_csr("trap_mscratch", 12'h340, 64'd0);

        // Instruction presented during the flush is discarded
        idle();
        valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd9; wdata_i = 64'h77;
        csr_wen_i = 1'b1; csr_addr_i = 12'h340; csr_wdata_i = 64'h99;
        tick();
        chk("flush2_flush", 64'(flush_o), 64'd1);
        chk("flush2_redirect_valid", 64'(redirect_valid_o), 64'd0);
        chk("flush2_rf_wen", 64'(rf_wen_o), 64'd0);
        chk("flush2_retire", 64'(retire_o), 64'd0);
        tick();
        chk("flush_end", 64'(flush_o), 64'd0);
        chk("flush_end_rf_wen", 64'(rf_wen_o), 64'd0);
        chk("flush_end_rf_rd", 64'(rf_rd_o), 64'd5);
        rd_csr("flush_mscratch", 12'h340, 64'd0);
        idle();
        tick();

        // MRET with same-cycle mepc write: redirect uses the old mepc
        valid_i = 1'b1; mret_i = 1'b1;
        csr_wen_i = 1'b1; csr_addr_i = 12'h341; csr_wdata_i = 64'h123;
        tick();
        chk("mret_redirect_valid", 64'(redirect_valid_o), 64'd1);
        chk("mret_redirect_pc", redirect_pc_o, 64'h8000_0040);
        chk("mret_retire", 64'(retire_o), 64'd1);
        chk("mret_flush", 64'(flush_o), 64'd1);
        rd_csr("mret_mstatus", 12'h300, 64'h88);
        rd_csr("mret_mepc_masked", 12'h341, 64'h120);
        idle();
        tick();
        tick();
        chk("mret_flush_end", 64'(flush_o), 64'd0);

        // Same-cycle CSR write is not bypassed to the read port
        valid_i = 1'b1; csr_wen_i = 1'b1; csr_addr_i = 12'h340; csr_wdata_i = 64'hAA;
        rd_csr("mscratch_old", 12'h340, 64'd0);
        tick();
        idle();
        rd_csr("mscratch_new", 12'h340, 64'hAA);
        rd_csr("unmapped", 12'h123, 64'd0);

        // Counters
        csr_write(12'hB00, 64'd10);
`ifdef WB_COUNTERS_EN
        rd_csr("mcycle_wr", 12'hB00, 64'd10);
        tick();
        rd_csr("mcycle_inc", 12'hB00, 64'd11);
`else
        rd_csr("mcycle_absent", 12'hB00, 64'd0);
`endif
        valid_i = 1'b1; csr_wen_i = 1'b1; csr_addr_i = 12'hB02;
        csr_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        idle();
        valid_i = 1'b1;
`ifdef WB_COUNTERS_EN
        rd_csr("minstret_wr", 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        rd_csr("minstret_wr_absent", 12'hB02, 64'd0);
`endif
        tick();
        idle();
        rd_csr("minstret_wrap", 12'hB02, 64'd0);

        // Exception beats MRET
        valid_i = 1'b1; exception_i = 1'b1; mret_i = 1'b1;
        pc_i = 64'h8000_0200; mcause_i = 64'd3;
        tick();
        idle();
        chk("both_redirect_pc", redirect_pc_o, 64'h8000_0100);
        chk("both_retire", 64'(retire_o), 64'd0);
        rd_csr("both_mstatus", 12'h300, 64'h80);
        rd_csr("both_mcause", 12'h342, 64'd3);

        // Reset mid-flush
        reset = 1'b0;
        #1;
        chk("midrst_flush", 64'(flush_o), 64'd0);
        chk("midrst_redirect_valid", 64'(redirect_valid_o), 64'd0);
        rd_csr("midrst_mtvec", 12'h305, 64'h8000_0000);
        @(negedge clock);
        reset = 1'b1;
        valid_i = 1'b1; wen_i = 1'b1; rd_i = 5'd3; wdata_i = 64'h42;
        tick();
        idle();
        chk("postrst_rf_wen", 64'(rf_wen_o), 64'd1);
        chk("postrst_rf_wdata", rf_wdata_o, 64'h42);
        chk("postrst_flush", 64'(flush_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
